edge_pixel_streamer: RTL

- Buffered pixel source that drives the post-detection smoothing filter's `enb`/8-bit pixel input.
- Accepts edge-detector pixels through a valid/ready write port and stores them in an internal circular FIFO.
- Replays them as a raster stream: one `out_enb` strobe per pixel, a fixed idle gap between lines, a line-start marker and an end-of-frame pulse.
- Sits between the edge-detection core and the post-detection filter.

---
 rtl/edge_pixel_streamer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/edge_pixel_streamer.sv
// ----------------------------------------------------------------------------
// edge_pixel_streamer
//
// Buffers edge-detector pixels in a circular FIFO and replays them as a raster
// stream for the post-detection smoothing filter. Each line is LINE_WIDTH
// pixels long, lines are separated by LINE_GAP idle cycles, and a frame is
// NUM_LINES lines.
//
// Ports:
//   i_clk         system clock, all state on the rising edge
//   i_reset       asynchronous active-low reset (0 = reset)
//   i_start       one-cycle frame start pulse, honoured only when idle
//   i_in_valid    write-side pixel valid
//   i_in_pixel    write-side pixel
//   o_in_ready    FIFO not full (combinational)
//   o_out_enb     registered strobe: o_out_pixel carries a new pixel
//   o_out_pixel   registered pixel to the filter, held while o_out_enb=0
//   o_line_start  high with o_out_enb on column 0 of every line
//   o_frame_done  one-cycle pulse the cycle after the last pixel of a frame
//   o_busy        registered "state is not idle" (one cycle behind the FSM)
//   o_fifo_count  FIFO occupancy, 0..DEPTH
//
// Build option:
//   PIXEL_THRESHOLD_EN  when defined, o_out_pixel is binarised: all ones if
//                       the FIFO pixel >= THRESH, else zero. When undefined the
//                       pixel passes through unchanged and THRESH is unused.
// ----------------------------------------------------------------------------
module edge_pixel_streamer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned LINE_WIDTH = 640,
    parameter int unsigned NUM_LINES  = 480,
    parameter int unsigned LINE_GAP   = 2,
    parameter int unsigned THRESH     = 128
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_in_valid,
    input  logic [DATA_WIDTH-1:0] i_in_pixel,
    output logic                  o_in_ready,
    output logic                  o_out_enb,
    output logic [DATA_WIDTH-1:0] o_out_pixel,
    output logic                  o_line_start,
    output logic                  o_frame_done,
    output logic                  o_busy,
    output logic [ADDR_WIDTH:0]   o_fifo_count
);

    // Counter widths, kept at least one bit so degenerate sizes still build.
    localparam int unsigned COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int unsigned ROW_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int unsigned GAP_W = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

    localparam logic [COL_W-1:0]    COL_LAST   = COL_W'(LINE_WIDTH - 1);
    localparam logic [ROW_W-1:0]    ROW_LAST   = ROW_W'(NUM_LINES - 1);
    // Unreachable when LINE_GAP=0: the GAP state is never entered then.
    localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'(LINE_GAP - 1);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    if (DEPTH != (1 << ADDR_WIDTH) || DEPTH < 2 || LINE_WIDTH < 1 || NUM_LINES < 1 ||
        (THRESH >> DATA_WIDTH) != 0) begin : g_param_check
        $error("edge_pixel_streamer: inconsistent parameters");
    end

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StGap,
        StDone
    } state_t;

    state_t                r_state;
    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [GAP_W-1:0]      r_gap;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;

    logic                  r_out_enb;
    logic [DATA_WIDTH-1:0] r_out_pixel;
    logic                  r_line_start;
    logic                  r_frame_done;
    logic                  r_busy;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic [DATA_WIDTH-1:0] w_rd_pixel;
    logic [DATA_WIDTH-1:0] w_out_pixel;

    assign w_full     = (r_count == FULL_COUNT);
    assign w_empty    = (r_count == '0);
    assign w_wr_fire  = i_in_valid && !w_full;
    assign w_rd_fire  = (r_state == StStream) && !w_empty;
    assign w_rd_pixel = r_mem[r_rd_ptr];

`ifdef PIXEL_THRESHOLD_EN
    assign w_out_pixel = (w_rd_pixel >= DATA_WIDTH'(THRESH)) ? '1 : '0;
`else
    assign w_out_pixel = w_rd_pixel;
`endif

    // FIFO storage needs no reset: only pointer/count state defines validity.
    always_ff @(posedge i_clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr] <= i_in_pixel;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_fire && !w_rd_fire) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr_fire && w_rd_fire) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Raster FSM with registered outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= StIdle;
            r_col        <= '0;
            r_row        <= '0;
            r_gap        <= '0;
            r_out_enb    <= 1'b0;
            r_out_pixel  <= '0;
            r_line_start <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_out_enb    <= 1'b0;
            r_line_start <= 1'b0;
            r_frame_done <= 1'b0;
            // Registered view of the state, so busy stays high through the
            // frame_done cycle and drops one cycle later.
            r_busy       <= (r_state != StIdle);

            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state <= StStream;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                StStream: begin
                    // An empty FIFO simply holds everything (underflow stall).
                    if (w_rd_fire) begin
                        r_out_enb    <= 1'b1;
                        r_out_pixel  <= w_out_pixel;
                        r_line_start <= (r_col == '0);
                        if (r_col == COL_LAST) begin
                            r_col <= '0;
                            if (r_row == ROW_LAST) begin
                                r_state <= StDone;
                            end else begin
                                r_row <= r_row + 1'b1;
                                r_gap <= '0;
                                if (LINE_GAP != 0) begin
                                    r_state <= StGap;
                                end
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                StGap: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= StStream;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                StDone: begin
                    r_frame_done <= 1'b1;
                    r_state      <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_in_ready   = !w_full;
    assign o_out_enb    = r_out_enb;
    assign o_out_pixel  = r_out_pixel;
    assign o_line_start = r_line_start;
    assign o_frame_done = r_frame_done;
    assign o_busy       = r_busy;
    assign o_fifo_count = r_count;

endmodule
